fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/nanorisc_pkg.sv | 14 +
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanorisc_pkg.sv
// Shared nanoRISC definitions: default datapath widths and the fetch FSM state type.
package nanorisc_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] FETCH_COUNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding read, a single-entry instruction holding
// register toward decode, and redirect handling that drops stale read data.
module fetch_unit
  import nanorisc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              PCWrite,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [7:0]        fetch_count,
  output fetch_state_t      fsm_state
);

  // Handshakes: imem_rd stays high from request until the cycle imem_ack is
  // seen; instr is transferred to decode in a cycle with instr_valid and
  // instr_ready both high, and instr is held stable while valid and not ready.

  fetch_state_t state, state_next;
  logic         drop, drop_next;
  logic         instr_load;
  logic         valid_set;
  logic         valid_clr;
  logic         count_inc;
  logic         pc_write;
  logic [ADDR_W-1:0] pc_target;
  logic         rd_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      drop        <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      if (instr_load) begin
        instr <= imem_data;
      end
      if (valid_set) begin
        instr_valid <= 1'b1;
      end else if (valid_clr) begin
        instr_valid <= 1'b0;
      end
      if (count_inc && (fetch_count != FETCH_COUNT_MAX)) begin
        fetch_count <= fetch_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    drop_next  = drop;
    instr_load = 1'b0;
    valid_set  = 1'b0;
    valid_clr  = 1'b0;
    count_inc  = 1'b0;
    pc_write   = 1'b0;
    pc_target  = '0;
    rd_req     = 1'b0;

    case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
        if (redirect) begin
          pc_write  = 1'b1;
          pc_target = redirect_target;
        end
      end

      ST_REQ: begin
        rd_req = 1'b1;
        if (redirect) begin
          pc_write  = 1'b1;
          pc_target = redirect_target;
          // An ack this cycle retires the stale read; otherwise the read in
          // flight belongs to the old path and its data must be thrown away.
          drop_next = !imem_ack;
        end else if (imem_ack) begin
          if (drop) begin
            drop_next = 1'b0;
          end else begin
            instr_load = 1'b1;
            valid_set  = 1'b1;
            pc_write   = 1'b1;
            pc_target  = pc + ADDR_W'(1);
            state_next = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_write   = 1'b1;
          pc_target  = redirect_target;
          valid_clr  = 1'b1;
          state_next = ST_REQ;
        end else if (instr_ready) begin
          valid_clr  = 1'b1;
          count_inc  = 1'b1;
          state_next = ST_REQ;
        end
      end

      default: begin
        state_next = ST_IDLE;
        drop_next  = 1'b0;
      end
    endcase

    // Reset abandons any read and suppresses PC updates in the same cycle.
    if (reset) begin
      rd_req    = 1'b0;
      pc_write  = 1'b0;
      pc_target = '0;
    end
  end

  assign imem_rd   = rd_req;
  assign imem_addr = pc;
  assign PCWrite   = pc_write;
  assign next_pc   = pc_target;
  assign fsm_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level reference model of the fetch/decode handoff.
module tb_fetch_unit;
  import nanorisc_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic [7:0] next_pc;
  logic       PCWrite;
  logic       imem_rd;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       imem_ack;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [7:0] redirect_target;
  logic [7:0] fetch_count;
  fetch_state_t fsm_state;

  fetch_unit #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock(clk),
    .reset(reset),
    .pc(pc),
    .next_pc(next_pc),
    .PCWrite(PCWrite),
    .imem_rd(imem_rd),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .imem_ack(imem_ack),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .fetch_count(fetch_count),
    .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: has fetching started since reset, is an instruction
  // parked for decode, and is the read in flight known to be stale.
  bit         m_started;
  bit         m_holding;
  bit         m_discard;
  bit         m_valid;
  logic [7:0] m_held;
  int         m_count;
  int         m_accepts;

  // Values seen at the last sample point, for directed checks.
  bit         s_rd;
  bit         s_pcw;
  logic [7:0] s_next;
  logic [7:0] s_addr;

  // ---------------- memory responder ----------------
  bit mem_auto = 1'b0;
  int mem_wait = -1;

  task automatic mem_drive();
    imem_ack  = 1'b0;
    imem_data = 8'($urandom);
    if (mem_wait > 0) begin
      mem_wait--;
      if (mem_wait == 0) begin
        imem_ack = 1'b1;
        mem_wait = -1;
      end
    end else if (imem_rd) begin
      mem_wait = $urandom_range(1, 3);
    end else if ($urandom_range(0, 7) == 0) begin
      imem_ack = 1'b1;
    end
  endtask

  // One clock cycle: inputs already driven, sample at negedge, advance model,
  // then clock the external program counter from the DUT's write port.
  task automatic step();
    bit         e_rd;
    bit         e_pcw;
    logic [7:0] e_next;
    #1;
    if (mem_auto) mem_drive();
    @(negedge clk);
    s_rd   = imem_rd;
    s_pcw  = PCWrite;
    s_next = next_pc;
    s_addr = imem_addr;

    e_rd   = !reset && m_started && !m_holding;
    e_pcw  = 1'b0;
    e_next = 8'h00;
    if (!reset) begin
      if (redirect) begin
        e_pcw  = 1'b1;
        e_next = redirect_target;
      end else if (e_rd && imem_ack && !m_discard) begin
        e_pcw  = 1'b1;
        e_next = pc + 8'd1;
      end
    end

    check_eq("imem_rd", imem_rd, e_rd);
    if (e_rd) check_eq("imem_addr", imem_addr, pc);
    check_eq("pcwrite", PCWrite, e_pcw);
    if (e_pcw || reset) check_eq("next_pc", next_pc, e_next);
    check_eq("instr_valid", instr_valid, m_valid);
    if (m_valid) check_eq("instr", instr, m_held);
    check_eq("fetch_count", fetch_count, m_count);

    if (reset) begin
      m_started = 0; m_holding = 0; m_discard = 0; m_valid = 0;
      m_held = 8'h00; m_count = 0;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_holding) begin
      if (redirect) begin
        m_holding = 0; m_valid = 0;
      end else if (instr_ready) begin
        m_holding = 0; m_valid = 0;
        m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
        m_accepts++;
      end
    end else if (imem_ack) begin
      if (redirect || m_discard) begin
        m_discard = 0;
      end else begin
        m_held = imem_data; m_valid = 1; m_holding = 1;
      end
    end else if (redirect) begin
      m_discard = 1;
    end

    @(posedge clk);
    #1;
    if (reset) pc = 8'h00;
    else if (s_pcw) pc = s_next;
  endtask

  task automatic drive(input bit rst, input bit ack, input logic [7:0] data,
                       input bit rdy, input bit redir, input logic [7:0] tgt);
    reset           = rst;
    imem_ack        = ack;
    imem_data       = data;
    instr_ready     = rdy;
    redirect        = redir;
    redirect_target = tgt;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; pc = 8'h00; imem_ack = 0; imem_data = 0;
    instr_ready = 0; redirect = 0; redirect_target = 0;
    m_started = 0; m_holding = 0; m_discard = 0; m_valid = 0;
    m_held = 0; m_count = 0; m_accepts = 0;
    @(posedge clk);
    #1;

    // Reset, first fetch at 0x00 acked two cycles after the request.
    drive(1, 0, 8'h00, 0, 0, 8'h00);
    drive(1, 0, 8'h00, 0, 0, 8'h00);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_count", fetch_count, 0);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    check_eq("idle_rd", s_rd, 0);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    check_eq("req_rd", s_rd, 1);
    check_eq("req_addr", s_addr, 8'h00);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    drive(0, 1, 8'hA5, 0, 0, 8'h00);
    check_eq("a5_pcw", s_pcw, 1);
    check_eq("a5_next", s_next, 8'h01);
    check_eq("a5_instr", instr, 8'hA5);
    check_eq("a5_valid", instr_valid, 1);

    // Accept, then fetch at 0xFF to exercise PC wrap.
    drive(0, 0, 8'h00, 1, 0, 8'h00);
    check_eq("acc1_count", fetch_count, 1);
    pc = 8'hFF;
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    drive(0, 1, 8'h3C, 0, 0, 8'h00);
    check_eq("wrap_pcw", s_pcw, 1);
    check_eq("wrap_next", s_next, 8'h00);

    // Decode stalls for five cycles; a stray ack in HOLD is ignored.
    for (int i = 0; i < 5; i++) begin
      drive(0, (i == 2), 8'h99, 0, 0, 8'h00);
      check_eq("stall_pcw", s_pcw, 0);
      check_eq("stall_rd", s_rd, 0);
      check_eq("stall_instr", instr, 8'h3C);
    end
    drive(0, 0, 8'h00, 1, 0, 8'h00);
    check_eq("acc2_count", fetch_count, 2);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    check_eq("post_acc_rd", s_rd, 1);

    // Redirect while waiting: the in-flight ack is dropped.
    drive(0, 0, 8'h00, 0, 1, 8'h40);
    check_eq("redir_pcw", s_pcw, 1);
    check_eq("redir_next", s_next, 8'h40);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    check_eq("redir_addr", s_addr, 8'h40);
    drive(0, 1, 8'h77, 0, 0, 8'h00);
    check_eq("drop_pcw", s_pcw, 0);
    check_eq("drop_valid", instr_valid, 0);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    drive(0, 1, 8'h11, 0, 0, 8'h00);
    check_eq("tgt_next", s_next, 8'h41);
    check_eq("tgt_instr", instr, 8'h11);
    drive(0, 0, 8'h00, 1, 0, 8'h00);

    // Redirect coincident with ack discards the data.
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    drive(0, 1, 8'h55, 0, 1, 8'h20);
    check_eq("coin_next", s_next, 8'h20);
    check_eq("coin_valid", instr_valid, 0);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    check_eq("coin_rd", s_rd, 1);
    check_eq("coin_addr", s_addr, 8'h20);

    // Reset mid-request, then a late ack lands in IDLE.
    drive(1, 0, 8'h00, 0, 0, 8'h00);
    check_eq("mid_rst_rd", s_rd, 0);
    check_eq("mid_rst_pcw", s_pcw, 0);
    check_eq("mid_rst_count", fetch_count, 0);
    drive(0, 1, 8'h66, 0, 0, 8'h00);
    check_eq("late_pcw", s_pcw, 0);
    check_eq("late_valid", instr_valid, 0);
    drive(0, 0, 8'h00, 0, 0, 8'h00);
    check_eq("late_rd", s_rd, 1);

    // Randomized traffic with the responding memory enabled.
    mem_auto = 1'b1;
    mem_wait = -1;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (reset) mem_wait = -1;
      instr_ready     = 1'($urandom);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = 8'($urandom);
      step();
    end

    // Saturation: accept more than 255 instructions after a reset.
    reset = 1'b1; redirect = 0; instr_ready = 0; mem_wait = -1;
    step();
    reset = 1'b0; instr_ready = 1'b1; m_accepts = 0;
    for (int i = 0; i < 4000 && m_accepts < 260; i++) begin
      step();
    end
    check_eq("sat_budget", (m_accepts >= 260), 1);
    check_eq("sat_count", fetch_count, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
